sram_512x32_ctrl: RTL and testbench

//  Initiator-side controller for the 512x32 single-port synchronous SRAM wrapper.

---
 rtl/sram_ctrl_pkg.sv | 12 +
 rtl/sram_512x32_ctrl_resp_fifo2.sv | 39 +++
 rtl/sram_512x32_ctrl.sv | 92 +++++++++
 tb/tb_sram_512x32_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared sizes and FSM state type for the 512x32 SRAM initiator controller.
package sram_ctrl_pkg;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DEPTH     = 512;
  localparam int unsigned RSP_DEPTH = 2;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;
endpackage

// File: rtl/sram_512x32_ctrl_resp_fifo2.sv
// Two-entry response FIFO holding read data until the consumer takes it.
module resp_fifo2
  import sram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);
  logic [DATA_W-1:0] mem [RSP_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/sram_512x32_ctrl.sv
// Request/response front end for the 512x32 single-port SRAM wrapper, with an
// optional post-reset fill of the whole array.
module sram_512x32_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter bit                INIT_CLEAR = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              INIT_DONE,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WEN,
  output logic [DATA_W-1:0] SRAM_DATA_IN,
  input  logic [DATA_W-1:0] SRAM_DATA_OUT
);
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              pend;
  logic              accept;
  logic              fill_wr;
  logic              pop;
  logic [1:0]        fifo_count;
  logic [2:0]        credit_used;

  // RST gates the fill strobe so the wrapper sees WEN=1 while reset is held.
  assign fill_wr     = (state == ST_INIT) && INIT_CLEAR && !RST;
  assign pop         = RSP_VALID && RSP_READY;
  assign credit_used = {1'b0, fifo_count} + {2'b00, pend} - {2'b00, pop};
  assign REQ_READY   = (state == ST_RUN) && (credit_used < 3'd2);
  assign accept      = REQ_VALID && REQ_READY;
  assign RSP_VALID   = (fifo_count != 2'd0);

  always_comb begin
    SRAM_ADDR    = addr_q;
    SRAM_DATA_IN = data_q;
    SRAM_WEN     = 1'b1;
    if (fill_wr) begin
      SRAM_ADDR    = cnt;
      SRAM_DATA_IN = INIT_VALUE;
      SRAM_WEN     = 1'b0;
    end else if (accept) begin
      SRAM_ADDR    = REQ_ADDR;
      SRAM_DATA_IN = REQ_WDATA;
      SRAM_WEN     = ~REQ_WE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_INIT;
      cnt       <= '0;
      INIT_DONE <= 1'b0;
      pend      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      pend   <= accept && !REQ_WE;
      // Capturing the driven strobes lets idle cycles hold the last address/data.
      addr_q <= SRAM_ADDR;
      data_q <= SRAM_DATA_IN;
      if (state == ST_INIT) begin
        if (!INIT_CLEAR || cnt == ADDR_W'(DEPTH - 1)) begin
          state     <= ST_RUN;
          INIT_DONE <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  resp_fifo2 u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (pend),
    .pop   (pop),
    .din   (SRAM_DATA_OUT),
    .count (fifo_count),
    .head  (RSP_RDATA)
  );
endmodule

// File: tb/tb_sram_512x32_ctrl.sv
// Directed plus randomized bench for sram_512x32_ctrl against a transaction-level model.
module tb_sram_512x32_ctrl;
  localparam logic [31:0] INIT_V = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID, REQ_WE, RSP_READY;
  logic [8:0]  REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic        REQ_READY, RSP_VALID, INIT_DONE, SRAM_WEN;
  logic [31:0] RSP_RDATA, SRAM_DATA_IN;
  logic [8:0]  SRAM_ADDR;

  logic        u2_req_valid, u2_req_we, u2_rsp_ready;
  logic [8:0]  u2_req_addr;
  logic [31:0] u2_req_wdata, u2_sram_dout;
  logic        u2_req_ready, u2_rsp_valid, u2_init_done, u2_sram_wen;
  logic [31:0] u2_rsp_rdata, u2_sram_data_in;
  logic [8:0]  u2_sram_addr;

  always #5 CLK = ~CLK;

  // Behavioural SRAM wrapper: write on WEN=0, otherwise registered read.
  logic [31:0] sram [512];
  logic [31:0] sram_dout;
  int unsigned sram_writes = 0;
  bit          seeded = 1'b0;
  always @(posedge CLK) begin
    if (!seeded) begin
      foreach (sram[i]) sram[i] <= $urandom;
      seeded    <= 1'b1;
      sram_dout <= '0;
    end else if (!SRAM_WEN) begin
      sram[SRAM_ADDR] <= SRAM_DATA_IN;
      sram_writes     <= sram_writes + 1;
    end else begin
      sram_dout <= sram[SRAM_ADDR];
    end
  end

  sram_512x32_ctrl #(.INIT_CLEAR(1'b1), .INIT_VALUE(INIT_V)) u_dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .INIT_DONE(INIT_DONE), .SRAM_ADDR(SRAM_ADDR), .SRAM_WEN(SRAM_WEN),
    .SRAM_DATA_IN(SRAM_DATA_IN), .SRAM_DATA_OUT(sram_dout)
  );

  sram_512x32_ctrl #(.INIT_CLEAR(1'b0), .INIT_VALUE(32'hA5A5_5A5A)) u_dut_noclr (
    .CLK(CLK), .RST(RST), .REQ_VALID(u2_req_valid), .REQ_READY(u2_req_ready),
    .REQ_WE(u2_req_we), .REQ_ADDR(u2_req_addr), .REQ_WDATA(u2_req_wdata),
    .RSP_VALID(u2_rsp_valid), .RSP_READY(u2_rsp_ready), .RSP_RDATA(u2_rsp_rdata),
    .INIT_DONE(u2_init_done), .SRAM_ADDR(u2_sram_addr), .SRAM_WEN(u2_sram_wen),
    .SRAM_DATA_IN(u2_sram_data_in), .SRAM_DATA_OUT(u2_sram_dout)
  );

  typedef struct packed {
    logic [31:0] data;
    int unsigned n;
  } rsp_t;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] ref_mem [512];
  rsp_t        exp_q [$];
  int unsigned k;          // edges since reset released, saturating at 512
  int unsigned n;          // global cycle index
  logic [8:0]  last_addr;
  logic [31:0] last_data;
  logic        last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, REQ_READY, 0);
    chk({tag, "_rsp_valid"}, RSP_VALID, 0);
    chk({tag, "_rsp_rdata"}, RSP_RDATA, 0);
    chk({tag, "_init_done"}, INIT_DONE, 0);
    chk({tag, "_sram_wen"}, SRAM_WEN, 1);
    chk({tag, "_sram_addr"}, SRAM_ADDR, 0);
    chk({tag, "_sram_din"}, SRAM_DATA_IN, 0);
    chk({tag, "_u2_req_ready"}, u2_req_ready, 0);
    chk({tag, "_u2_init_done"}, u2_init_done, 0);
  endtask

  // One clock: check outputs at the falling edge, update the model, advance.
  task automatic tick();
    logic run_e, vld_e, pop_e, rdy_e, acc;
    int   sz;
    @(negedge CLK);
    last_acc = 1'b0;
    if (RST) begin
      check_reset("rst");
      exp_q.delete();
      k = 0;
      last_addr = '0;
      last_data = '0;
    end else begin
      sz    = exp_q.size();
      run_e = (k >= 512);
      vld_e = (sz > 0) && (exp_q[0].n + 2 <= n);
      pop_e = vld_e && RSP_READY;
      rdy_e = run_e && ((sz - int'(pop_e)) < 2);
      acc   = REQ_VALID && rdy_e;
      chk("req_ready", REQ_READY, rdy_e);
      chk("rsp_valid", RSP_VALID, vld_e);
      chk("init_done", INIT_DONE, run_e);
      if (vld_e) chk("rsp_rdata", RSP_RDATA, exp_q[0].data);
      if (!run_e) begin
        chk("fill_wen", SRAM_WEN, 0);
        chk("fill_addr", SRAM_ADDR, k);
        chk("fill_data", SRAM_DATA_IN, INIT_V);
        last_addr = k[8:0];
        last_data = INIT_V;
      end else if (acc) begin
        chk("req_addr", SRAM_ADDR, REQ_ADDR);
        chk("req_wen", SRAM_WEN, !REQ_WE);
        chk("req_data", SRAM_DATA_IN, REQ_WDATA);
        last_addr = REQ_ADDR;
        last_data = REQ_WDATA;
      end else begin
        chk("idle_wen", SRAM_WEN, 1);
        chk("idle_addr", SRAM_ADDR, last_addr);
        chk("idle_data", SRAM_DATA_IN, last_data);
      end
      if (pop_e) void'(exp_q.pop_front());
      if (acc) begin
        if (REQ_WE) ref_mem[REQ_ADDR] = REQ_WDATA;
        else exp_q.push_back('{data: ref_mem[REQ_ADDR], n: n});
      end
      last_acc = acc;
      chk("u2_req_ready", u2_req_ready, k >= 1);
      chk("u2_init_done", u2_init_done, k >= 1);
    end
    chk("u2_sram_wen", u2_sram_wen, 1);
    chk("u2_sram_addr", u2_sram_addr, 0);
    chk("u2_sram_din", u2_sram_data_in, 0);
    chk("u2_rsp_valid", u2_rsp_valid, 0);
    chk("u2_rsp_rdata", u2_rsp_rdata, 0);
    @(posedge CLK);
    if (!RST) begin
      if (k == 511) foreach (ref_mem[i]) ref_mem[i] = INIT_V;
      if (k < 512) k++;
    end
    n++;
    #1;
  endtask

  task automatic req(input logic we, input logic [8:0] addr, input logic [31:0] data);
    REQ_VALID = 1'b1;
    REQ_WE    = we;
    REQ_ADDR  = addr;
    REQ_WDATA = data;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("accept_timeout", last_acc, 1);
    REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  int unsigned wr0;
  int unsigned held_acc;

  initial begin
    RST = 1'b0;
    REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0; RSP_READY = 1'b1;
    u2_req_valid = 1'b0; u2_req_we = 1'b0; u2_req_addr = '0; u2_req_wdata = '0;
    u2_rsp_ready = 1'b1; u2_sram_dout = '0;
    k = 0; n = 0; last_addr = '0; last_data = '0; last_acc = 1'b0;
    #2 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_reset("por");
    RST = 1'b0;

    // Fill: 512 writes then INIT_DONE; read of an untouched word returns the fill value.
    wr0 = sram_writes;
    repeat (513) tick();
    chk("fill_write_count", sram_writes - wr0, 512);
    req(1'b0, 9'd300, '0);
    drain();

    // Write then immediate read of the same word.
    req(1'b1, 9'd5, 32'hDEAD_BEEF);
    req(1'b0, 9'd5, '0);
    drain();

    // Streaming reads with the consumer always ready.
    for (int i = 1; i <= 8; i++) req(1'b1, 9'(i), $urandom);
    for (int i = 1; i <= 8; i++) req(1'b0, 9'(i), '0);
    drain();

    // Backpressure: two reads fill the credits, the third waits for a pop.
    RSP_READY = 1'b0;
    req(1'b0, 9'd2, '0);
    req(1'b0, 9'd3, '0);
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 9'd4;
    held_acc = 0;
    repeat (4) begin
      tick();
      held_acc += int'(last_acc);
    end
    chk("held_accepts", held_acc, 0);
    RSP_READY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    chk("third_read_accept", last_acc, 1);
    REQ_VALID = 1'b0;
    drain();

    // Randomized traffic with random backpressure over a small address window.
    for (int i = 0; i < 400; i++) begin
      REQ_VALID = ($urandom_range(0, 9) < 7);
      REQ_WE    = $urandom_range(0, 1) == 1;
      REQ_ADDR  = 9'($urandom_range(0, 15));
      REQ_WDATA = $urandom;
      RSP_READY = ($urandom_range(0, 3) != 0);
      tick();
    end
    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    drain();

    // Reset with one response queued and one read pending.
    RSP_READY = 1'b0;
    req(1'b0, 9'd10, '0);
    req(1'b0, 9'd11, '0);
    RST = 1'b1;
    #1;
    check_reset("mid");
    tick();
    RST = 1'b0;
    RSP_READY = 1'b1;
    wr0 = sram_writes;
    repeat (513) tick();
    chk("refill_write_count", sram_writes - wr0, 512);
    req(1'b0, 9'd10, '0);
    req(1'b0, 9'd5, '0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
